// File: rtl/int_sync_crossing_sink_pend.sv
// Purpose: receive end of the interrupt sync crossing; synchronizes async interrupt levels
//          and presents each line as a level or as a latched edge with a clear handshake.
// Latency: input change -> auto_out in SYNC_STAGES+1 edges (SYNC_STAGES+FILTER_CYCLES+1 with
//          the glitch filter); clear handshake: clr_ready drops for one cycle per accepted clear.
// Optional feature macro: INT_SYNC_GLITCH_FILTER_EN (per-bit glitch filter after the sync chain).
module int_sync_crossing_sink_pend #(
    parameter int          WIDTH         = 4,
    parameter int          SYNC_STAGES   = 3,
    parameter int          FILTER_CYCLES = 4,
    parameter logic [31:0] EDGE_MASK     = 32'h0
) (
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic [WIDTH-1:0]                       auto_in_sync,
    input  logic                                   clr_valid,
    input  logic [((WIDTH > 1) ? $clog2(WIDTH) : 1)-1:0] clr_idx,
    output logic                                   clr_ready,
    output logic [WIDTH-1:0]                       auto_out,
    output logic                                   irq_any
);

    localparam int IDXW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    // Elaboration-time guard on illegal configurations.
    if (SYNC_STAGES < 2 || FILTER_CYCLES < 1) begin : g_bad_param
        $error("int_sync_crossing_sink_pend: SYNC_STAGES must be >= 2 and FILTER_CYCLES >= 1");
    end

    typedef enum logic [1:0] {
        ST_RST  = 2'd0,
        ST_IDLE = 2'd1,
        ST_BUSY = 2'd2
    } state_t;

    logic [WIDTH-1:0] r_sync [SYNC_STAGES];
    logic [WIDTH-1:0] w_s;
    logic [WIDTH-1:0] w_f;
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] r_out;
    logic [WIDTH-1:0] w_clr_hit;
    logic             w_accept;
    state_t           r_state;
    logic             r_clr_ready;

    // Plain flop chain per bit: nothing may sit between metastability stages.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                r_sync[k] <= '0;
            end
        end else begin
            r_sync[0] <= auto_in_sync;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                r_sync[k] <= r_sync[k-1];
            end
        end
    end

    assign w_s = r_sync[SYNC_STAGES-1];

`ifdef INT_SYNC_GLITCH_FILTER_EN
    localparam int CW = $clog2(FILTER_CYCLES + 1);

    logic [CW-1:0]    r_cnt [WIDTH];
    logic [WIDTH-1:0] r_filt;

    // Filtered value only follows the synchronized bit after FILTER_CYCLES consecutive
    // mismatching cycles; any shorter excursion resets the count and is dropped.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_filt <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (w_s[i] != r_filt[i]) begin
                    if (r_cnt[i] == CW'(FILTER_CYCLES - 1)) begin
                        r_filt[i] <= w_s[i];
                        r_cnt[i]  <= '0;
                    end else begin
                        r_cnt[i]  <= r_cnt[i] + CW'(1);
                    end
                end else begin
                    r_cnt[i] <= '0;
                end
            end
        end
    end

    assign w_f = r_filt;
`else
    assign w_f = w_s;
`endif

    // A clear is accepted whenever the requester is valid while we advertise ready.
    assign w_accept = clr_valid && r_clr_ready;

    // Decode the accepted clear into a one-hot hit; out-of-range indices hit nothing.
    always_comb begin
        w_clr_hit = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_clr_hit[i] = w_accept && (clr_idx == IDXW'(i));
        end
    end

    // Per-bit output: level lines register f, edge lines hold a pending flag where set beats clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_prev <= '0;
            r_out  <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (EDGE_MASK[i]) begin
                    r_prev[i] <= w_f[i];
                    if (w_f[i] && !r_prev[i]) begin
                        r_out[i] <= 1'b1;
                    end else if (w_clr_hit[i]) begin
                        r_out[i] <= 1'b0;
                    end
                end else begin
                    r_prev[i] <= 1'b0;
                    r_out[i]  <= w_f[i];
                end
            end
        end
    end

    // Clear handshake FSM: ready comes up one edge after reset release and drops for
    // exactly one cycle after each accepted request.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= ST_RST;
            r_clr_ready <= 1'b0;
        end else begin
            case (r_state)
                ST_RST: begin
                    r_state     <= ST_IDLE;
                    r_clr_ready <= 1'b1;
                end
                ST_IDLE: begin
                    if (clr_valid) begin
                        r_state     <= ST_BUSY;
                        r_clr_ready <= 1'b0;
                    end
                end
                ST_BUSY: begin
                    r_state     <= ST_IDLE;
                    r_clr_ready <= 1'b1;
                end
                default: begin
                    r_state     <= ST_RST;
                    r_clr_ready <= 1'b0;
                end
            endcase
        end
    end

    assign clr_ready = r_clr_ready;
    assign auto_out  = r_out;
    assign irq_any   = |r_out;

endmodule

// File: tb/tb_int_sync_crossing_sink_pend.sv
module tb_int_sync_crossing_sink_pend;

`ifdef INT_SYNC_GLITCH_FILTER_EN
    localparam int LAT = 3 + 4 + 1;
    localparam int PW  = 6;
`else
    localparam int LAT = 3 + 1;
    localparam int PW  = 3;
`endif

    logic       clock;
    logic       reset;
    logic [3:0] in4;
    logic       vld4;
    logic [1:0] idx4;
    logic       rdy4;
    logic [3:0] out4;
    logic       any4;
    logic [2:0] in3;
    logic       vld3;
    logic [1:0] idx3;
    logic       rdy3;
    logic [2:0] out3;
    logic       any3;

    int n_total = 0;
    int n_bad   = 0;

    int_sync_crossing_sink_pend #(
        .WIDTH(4), .SYNC_STAGES(3), .FILTER_CYCLES(4), .EDGE_MASK(32'hC)
    ) u_dut (
        .clock(clock), .reset(reset), .auto_in_sync(in4), .clr_valid(vld4),
        .clr_idx(idx4), .clr_ready(rdy4), .auto_out(out4), .irq_any(any4)
    );

    int_sync_crossing_sink_pend #(
        .WIDTH(3), .SYNC_STAGES(3), .FILTER_CYCLES(4), .EDGE_MASK(32'h4)
    ) u_dut_w3 (
        .clock(clock), .reset(reset), .auto_in_sync(in3), .clr_valid(vld3),
        .clr_idx(idx3), .clr_ready(rdy3), .auto_out(out3), .irq_any(any3)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        in4 = '0; vld4 = 1'b0; idx4 = '0;
        in3 = '0; vld3 = 1'b0; idx3 = '0;

        // Power-on reset
        tick(2);
        chk("por_out", out4, 4'b0000);
        chk("por_any", any4, 0);
        chk("por_rdy", rdy4, 0);
        #2 reset = 1'b0;
        tick(1);
        chk("por_rdy_up", rdy4, 1);
        chk("por_rdy_up_w3", rdy3, 1);

        // Level line: rise then fall, both with the same latency
        in4 = 4'b0001;
        tick(LAT - 1);
        chk("lvl_rise_early", out4, 4'b0000);
        tick(1);
        chk("lvl_rise", out4, 4'b0001);
        chk("lvl_rise_any", any4, 1);
        tick(6);
        in4 = 4'b0000;
        tick(LAT - 1);
        chk("lvl_fall_early", out4, 4'b0001);
        tick(1);
        chk("lvl_fall", out4, 4'b0000);
        chk("lvl_fall_any", any4, 0);
        tick(4);

        // Edge line: short pulse latched, then cleared through the handshake
        in4 = 4'b0100;
        for (int k = 1; k <= LAT + 4; k++) begin
            tick(1);
            if (k == PW) in4 = 4'b0000;
            if (k == LAT - 1) chk("edge_early", out4, 4'b0000);
            if (k == LAT) chk("edge_set", out4, 4'b0100);
        end
        chk("edge_held", out4, 4'b0100);
        chk("edge_any", any4, 1);
        vld4 = 1'b1; idx4 = 2'd2;
        tick(1);
        vld4 = 1'b0;
        chk("edge_clr_out", out4, 4'b0000);
        chk("edge_clr_rdy", rdy4, 0);
        chk("edge_clr_any", any4, 0);
        tick(1);
        chk("edge_clr_rdy_back", rdy4, 1);
        tick(4);

        // Collision: bit 3 rise reaches the pending flop on the accepting edge
        in4 = 4'b1000;
        tick(LAT - 1);
        chk("col_pre", out4, 4'b0000);
        vld4 = 1'b1; idx4 = 2'd3;
        tick(1);
        vld4 = 1'b0;
        chk("col_set_wins", out4, 4'b1000);
        chk("col_rdy", rdy4, 0);
        tick(1);
        vld4 = 1'b1; idx4 = 2'd3;
        tick(1);
        vld4 = 1'b0;
        chk("col_later_clr", out4, 4'b0000);
        in4 = 4'b0000;
        tick(LAT + 2);

        // No-effect clear on a level line; held valid is ignored while not ready
        in4 = 4'b0001;
        tick(LAT + 1);
        chk("noeff_pre", out4, 4'b0001);
        vld4 = 1'b1; idx4 = 2'd0;
        tick(1);
        chk("noeff_out", out4, 4'b0001);
        chk("noeff_rdy0", rdy4, 0);
        tick(1);
        chk("hold_rdy1", rdy4, 1);
        tick(1);
        chk("hold_rdy0", rdy4, 0);
        vld4 = 1'b0;
        tick(1);
        chk("hold_rdy_back", rdy4, 1);
        chk("noeff_out_end", out4, 4'b0001);
        in4 = 4'b0000;
        tick(LAT + 2);

        // WIDTH=3 build: out-of-range index accepted but changes nothing
        in3 = 3'b100;
        tick(PW);
        in3 = 3'b000;
        tick(LAT);
        chk("w3_pend", out3, 3'b100);
        vld3 = 1'b1; idx3 = 2'd3;
        tick(1);
        vld3 = 1'b0;
        chk("w3_oor_out", out3, 3'b100);
        chk("w3_oor_rdy", rdy3, 0);
        chk("w3_any", any3, 1);
        tick(1);
        vld3 = 1'b1; idx3 = 2'd2;
        tick(1);
        vld3 = 1'b0;
        chk("w3_clr", out3, 3'b000);
        tick(2);

`ifdef INT_SYNC_GLITCH_FILTER_EN
        // Glitch filter: 2-cycle pulse dropped, 6-cycle pulse passes at edge 8
        in4 = 4'b0001;
        tick(2);
        in4 = 4'b0000;
        for (int k = 0; k < 12; k++) begin
            tick(1);
            if (out4 != 4'b0000) chk("flt_glitch", out4, 4'b0000);
        end
        chk("flt_glitch_end", out4, 4'b0000);
        in4 = 4'b0001;
        for (int k = 1; k <= 8; k++) begin
            tick(1);
            if (k == 6) in4 = 4'b0000;
            if (k == 7) chk("flt_early", out4, 4'b0000);
            if (k == 8) chk("flt_pass", out4, 4'b0001);
        end
        tick(LAT + 2);
`endif

        // Mid-operation reset discards a pending edge immediately
        in4 = 4'b0100;
        tick(PW);
        in4 = 4'b0000;
        tick(LAT);
        chk("rst_pend_pre", out4, 4'b0100);
        #3 reset = 1'b1;
        #1;
        chk("rst_mid_out", out4, 4'b0000);
        chk("rst_mid_any", any4, 0);
        chk("rst_mid_rdy", rdy4, 0);
        #2 reset = 1'b0;
        tick(1);
        chk("rst_rel_rdy", rdy4, 1);
        chk("rst_rel_out", out4, 4'b0000);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
